hazard_stall_gen: RTL and testbench

Hazard and stall source for the 5-stage core; produces the load_hazard, branch_hazard, stall_pipl, mret_type and interrupt inputs that the pipeline controller turns into register clears and enables. It combines combinational hazard detection with two sequential engines:
- a data-bus wait/timeout FSM that drives stall_pipl;
- an interrupt acceptance FSM that injects a one-cycle interrupt pulse only at a safe pipeline boundary.

---
 rtl/hazard_stall_gen.sv | 175 +++++++++++++++++
 tb/tb_hazard_stall_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_gen.sv
// hazard_stall_gen: hazard and stall source for the 5-stage core.
// Combinational load-use / redirect / MRET hazards, a data-bus wait/timeout
// FSM driving stall_pipl, and an interrupt acceptance FSM that injects a
// one-cycle interrupt only at a safe pipeline boundary.
// Optional: define HAZARD_PERF_CNT_EN to build the 32-bit stall-cycle counter.
module hazard_stall_gen #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  exe_rd,
  input  logic        exe_mem_read,
  input  logic        exe_branch_taken,
  input  logic        exe_mret,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        irq_req,
  input  logic        irq_enable,
  output logic        load_hazard,
  output logic        branch_hazard,
  output logic        mret_type,
  output logic        stall_pipl,
  output logic        interrupt,
  output logic        irq_ack,
  output logic        bus_err,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_WAIT,
    BUS_ERR
  } bus_state_e;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_PEND,
    IRQ_TAKE,
    IRQ_HOLD
  } irq_state_e;

  // Last stalled wait count: the stall window is TIMEOUT_CYCLES-1 cycles long,
  // counting the IDLE cycle that launches the wait as cycle 1.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bus_state_e       bus_state_q, bus_state_d;
  irq_state_e       irq_state_q, irq_state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             bus_err_q, bus_err_d;
  logic             irq_take_q, irq_take_d;
  logic             stall_raw;
  logic             load_use_raw;
  logic             irq_safe;

  // Bus wait/timeout next-state and raw stall request
  always_comb begin
    bus_state_d  = bus_state_q;
    wait_cnt_d   = wait_cnt_q;
    stall_raw    = 1'b0;
    wait_cnt_inc = wait_cnt_q + 1'b1;
    unique case (bus_state_q)
      BUS_IDLE: begin
        if (mem_req && !mem_ack) begin
          stall_raw  = 1'b1;
          wait_cnt_d = CNT_W'(1);
          bus_state_d = (TIMEOUT_LAST == CNT_W'(1)) ? BUS_ERR : BUS_WAIT;
        end
      end
      BUS_WAIT: begin
        if (mem_ack) begin
          bus_state_d = BUS_IDLE;
          wait_cnt_d  = '0;
        end else begin
          stall_raw = 1'b1;
          if (!mem_req) begin
            bus_state_d = BUS_IDLE;
            wait_cnt_d  = '0;
          end else if (wait_cnt_inc == TIMEOUT_LAST) begin
            bus_state_d = BUS_ERR;
            wait_cnt_d  = '0;
          end else begin
            wait_cnt_d = wait_cnt_inc;
          end
        end
      end
      BUS_ERR: begin
        bus_state_d = BUS_IDLE;
        wait_cnt_d  = '0;
      end
      default: begin
        bus_state_d = BUS_IDLE;
        wait_cnt_d  = '0;
      end
    endcase
    bus_err_d = (bus_state_d == BUS_ERR);
  end

  // Stall is a same-cycle response to the bus; reset forces it low at once
  // even though it is decoded from inputs as well as state.
  assign stall_pipl = stall_raw & reset_n;

  // Combinational hazards, suppressed while the pipeline is frozen
  always_comb begin
    load_use_raw = exe_mem_read && (exe_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == exe_rd)) ||
                    (id_use_rs2 && (id_rs2 == exe_rd)));
    load_hazard   = load_use_raw & ~stall_pipl;
    branch_hazard = exe_branch_taken & ~stall_pipl;
    mret_type     = exe_mret & ~stall_pipl;
  end

  // Interrupt acceptance next-state
  always_comb begin
    irq_state_d = irq_state_q;
    irq_safe    = ~stall_pipl & ~branch_hazard & ~mret_type & ~load_hazard & irq_enable;
    unique case (irq_state_q)
      IRQ_IDLE: if (irq_req && irq_enable) irq_state_d = IRQ_PEND;
      IRQ_PEND: begin
        if (!irq_req)      irq_state_d = IRQ_IDLE;
        else if (irq_safe) irq_state_d = IRQ_TAKE;
      end
      IRQ_TAKE: irq_state_d = IRQ_HOLD;
      IRQ_HOLD: if (!irq_req || exe_mret) irq_state_d = IRQ_IDLE;
      default:  irq_state_d = IRQ_IDLE;
    endcase
    irq_take_d = (irq_state_d == IRQ_TAKE);
  end

  // FSM state and registered pulse outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_state_q <= BUS_IDLE;
      irq_state_q <= IRQ_IDLE;
      wait_cnt_q  <= '0;
      bus_err_q   <= 1'b0;
      irq_take_q  <= 1'b0;
    end else begin
      bus_state_q <= bus_state_d;
      irq_state_q <= irq_state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
      irq_take_q  <= irq_take_d;
    end
  end

  assign bus_err   = bus_err_q;
  assign interrupt = irq_take_q;
  assign irq_ack   = irq_take_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  // Free-running stall-cycle counter, wraps naturally
  always_comb begin
    perf_cnt_d = perf_cnt_q + {31'd0, (stall_pipl | load_hazard)};
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf_cnt_q <= '0;
    else          perf_cnt_q <= perf_cnt_d;
  end

  assign perf_stall_cnt = perf_cnt_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_gen.sv
// Scoreboard bench for hazard_stall_gen: each driven cycle pushes its
// hand-computed expected outputs; a monitor pops and compares at negedge.
module tb_hazard_stall_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs1, id_rs2, exe_rd;
  logic        id_use_rs1, id_use_rs2, exe_mem_read, exe_branch_taken, exe_mret;
  logic        mem_req, mem_ack, irq_req, irq_enable;
  logic        load_hazard, branch_hazard, mret_type, stall_pipl;
  logic        interrupt, irq_ack, bus_err;
  logic [31:0] perf_stall_cnt;

  hazard_stall_gen #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .exe_rd(exe_rd), .exe_mem_read(exe_mem_read), .exe_branch_taken(exe_branch_taken),
    .exe_mret(exe_mret), .mem_req(mem_req), .mem_ack(mem_ack),
    .irq_req(irq_req), .irq_enable(irq_enable),
    .load_hazard(load_hazard), .branch_hazard(branch_hazard), .mret_type(mret_type),
    .stall_pipl(stall_pipl), .interrupt(interrupt), .irq_ack(irq_ack),
    .bus_err(bus_err), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [6:0]  exp;   // {lh, bh, mt, stall, interrupt, irq_ack, bus_err}
    logic [31:0] perf;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] perf_model = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_dp();
    id_rs1 = 0; id_rs2 = 0; exe_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; exe_mem_read = 0;
    exe_branch_taken = 0; exe_mret = 0;
  endtask

  // Push the expected outputs of the cycle whose inputs were just driven
  task automatic push(input string nm, input logic lh, input logic bh, input logic mt,
                      input logic st, input logic irq_p, input logic berr,
                      input bit in_rst = 0);
    exp_t e;
    e.nm  = nm;
    e.exp = {lh, bh, mt, st, irq_p, irq_p, berr};
`ifdef HAZARD_PERF_CNT_EN
    if (in_rst) perf_model = 0;
    e.perf = perf_model;
    if (!in_rst && (st || lh)) perf_model = perf_model + 1;
`else
    e.perf = 0;
`endif
    sb.push_back(e);
  endtask

  // Monitor: compare every scoreboard entry against the DUT mid-cycle
  initial begin
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        act = {load_hazard, branch_hazard, mret_type, stall_pipl, interrupt, irq_ack, bus_err};
        total++;
        if (act !== e.exp || perf_stall_cnt !== e.perf) begin
          bad++;
          $display("FAIL %s: got lh/bh/mt/st/int/ack/berr=%b perf=%0d, want %b perf=%0d",
                   e.nm, act, perf_stall_cnt, e.exp, e.perf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; clr_dp();
    mem_req = 1; mem_ack = 0; irq_req = 0; irq_enable = 1;
    repeat (2) @(posedge clk);

    // Reset state: stall gated even with a request outstanding
    tick(); push("reset", 0,0,0,0,0,0, 1);
    tick(); reset_n = 1; mem_req = 0; push("rst_rel", 0,0,0,0,0,0);

    // Combinational hazards
    tick(); exe_mem_read = 1; exe_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    push("lh_rs2", 1,0,0,0,0,0);
    tick(); exe_rd = 0; push("lh_rd0", 0,0,0,0,0,0);
    tick(); clr_dp(); exe_mem_read = 1; exe_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
    push("lh_rs1", 1,0,0,0,0,0);
    tick(); id_use_rs1 = 0; push("lh_nouse", 0,0,0,0,0,0);
    tick(); id_use_rs1 = 1; exe_mem_read = 0; push("lh_noload", 0,0,0,0,0,0);
    tick(); clr_dp(); exe_branch_taken = 1; exe_mret = 1; push("bh_mt", 0,1,1,0,0,0);

    // Bus wait, ack on the 4th cycle; hazards masked while stalled
    tick(); clr_dp(); mem_req = 1; push("w_c1", 0,0,0,1,0,0);
    tick(); exe_branch_taken = 1; exe_mret = 1; exe_mem_read = 1; exe_rd = 3;
    id_rs1 = 3; id_use_rs1 = 1; push("w_c2_mask", 0,0,0,1,0,0);
    tick(); clr_dp(); push("w_c3", 0,0,0,1,0,0);
    tick(); mem_ack = 1; push("w_ack", 0,0,0,0,0,0);
    tick(); mem_req = 0; push("w_late_ack", 0,0,0,0,0,0);
    tick(); mem_req = 1; mem_ack = 1; push("zero_wait", 0,0,0,0,0,0);
    tick(); mem_req = 0; mem_ack = 0; push("w_idle", 0,0,0,0,0,0);

    // Request dropped mid-wait: back to idle, no error
    tick(); mem_req = 1; push("drop_c1", 0,0,0,1,0,0);
    tick(); mem_req = 0; push("drop_c2", 0,0,0,1,0,0);
    tick(); push("drop_c3", 0,0,0,0,0,0);
    tick(); push("drop_c4", 0,0,0,0,0,0);

    // Timeout: 15 stalled cycles then a one-cycle bus_err
    for (int i = 0; i < 15; i++) begin
      tick(); mem_req = 1; push($sformatf("to_stall%0d", i), 0,0,0,1,0,0);
    end
    tick(); mem_ack = 1; push("to_err", 0,0,0,0,0,1);
    tick(); mem_req = 0; push("to_after", 0,0,0,0,0,0);
    tick(); mem_ack = 0; push("to_idle", 0,0,0,0,0,0);

    // Interrupt during a 3-cycle bus stall, taken right after the stall
    tick(); mem_req = 1; irq_req = 1; push("irq_s1", 0,0,0,1,0,0);
    tick(); push("irq_s2", 0,0,0,1,0,0);
    tick(); push("irq_s3", 0,0,0,1,0,0);
    tick(); mem_ack = 1; push("irq_ack_cyc", 0,0,0,0,0,0);
    tick(); mem_req = 0; mem_ack = 0; push("irq_take", 0,0,0,0,1,0);
    tick(); push("irq_hold1", 0,0,0,0,0,0);
    tick(); push("irq_hold2", 0,0,0,0,0,0);
    tick(); irq_req = 0; push("irq_low", 0,0,0,0,0,0);
    tick(); irq_req = 1; push("irq_re1", 0,0,0,0,0,0);
    tick(); push("irq_re2", 0,0,0,0,0,0);
    tick(); push("irq_re_take", 0,0,0,0,1,0);
    // MRET releases the hold even with irq_req still high
    tick(); exe_mret = 1; push("irq_mret", 0,0,1,0,0,0);
    tick(); exe_mret = 0; push("irq_mret_pend", 0,0,0,0,0,0);
    // Redirect wins over a pending interrupt
    tick(); exe_branch_taken = 1; push("irq_vs_br", 0,1,0,0,0,0);
    tick(); exe_branch_taken = 0; push("irq_br_safe", 0,0,0,0,0,0);
    tick(); push("irq_br_take", 0,0,0,0,1,0);
    tick(); irq_req = 0; push("irq_br_rel", 0,0,0,0,0,0);

    // irq_enable low holds the request pending
    tick(); irq_req = 1; push("ien_p", 0,0,0,0,0,0);
    tick(); irq_enable = 0; push("ien_off1", 0,0,0,0,0,0);
    tick(); push("ien_off2", 0,0,0,0,0,0);
    tick(); irq_enable = 1; push("ien_on", 0,0,0,0,0,0);
    tick(); push("ien_take", 0,0,0,0,1,0);
    tick(); irq_req = 0; push("ien_rel", 0,0,0,0,0,0);

    // Request withdrawn while pending: never taken
    tick(); irq_req = 1; push("wd_p", 0,0,0,0,0,0);
    tick(); irq_req = 0; push("wd_drop", 0,0,0,0,0,0);
    tick(); push("wd_none1", 0,0,0,0,0,0);
    tick(); push("wd_none2", 0,0,0,0,0,0);

    // Load hazard blocks the take
    tick(); irq_req = 1; push("lhb_p", 0,0,0,0,0,0);
    tick(); exe_mem_read = 1; exe_rd = 9; id_rs2 = 9; id_use_rs2 = 1;
    push("lhb_haz", 1,0,0,0,0,0);
    tick(); clr_dp(); push("lhb_safe", 0,0,0,0,0,0);
    tick(); push("lhb_take", 0,0,0,0,1,0);
    tick(); irq_req = 0; push("lhb_rel", 0,0,0,0,0,0);

    // Reset in BUS_WAIT
    tick(); mem_req = 1; push("rw_c1", 0,0,0,1,0,0);
    tick(); push("rw_c2", 0,0,0,1,0,0);
    tick(); reset_n = 0; push("rw_rst", 0,0,0,0,0,0, 1);
    tick(); reset_n = 1; mem_ack = 1; push("rw_zero", 0,0,0,0,0,0);
    tick(); mem_req = 0; mem_ack = 0; push("rw_idle", 0,0,0,0,0,0);

    // Reset with an interrupt pending discards it
    tick(); irq_req = 1; push("rp_p", 0,0,0,0,0,0);
    tick(); reset_n = 0; push("rp_rst", 0,0,0,0,0,0, 1);
    tick(); reset_n = 1; push("rp_rel", 0,0,0,0,0,0);
    tick(); push("rp_pend", 0,0,0,0,0,0);
    tick(); push("rp_take", 0,0,0,0,1,0);
    tick(); irq_req = 0; push("rp_end", 0,0,0,0,0,0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
